// File: rtl/btn_cond.sv
// Multi-channel push-button conditioner: 2-flop sync, per-channel debounce FSM, level + press pulse.
// Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module btn_cond #(
  parameter int unsigned N          = 4,
  parameter int unsigned DB_CYCLES  = 20,
  parameter int unsigned REP_DELAY  = 50,
  parameter int unsigned REP_PERIOD = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] btn_in,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_pulse
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  // Encoded as (level, counting) so the level is the state's upper bit.
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    PRESS_WAIT = 2'b01,
    HELD       = 2'b10,
    REL_WAIT   = 2'b11
  } state_e;

  logic [N-1:0]  s1_q, s2_q;
  state_e        state_q [N];
  state_e        state_d [N];
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [N-1:0]  pulse_q, pulse_d;

`ifdef BTN_REPEAT_EN
  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);

  // rep_arm: first repeat already fired, so the counter now measures REP_PERIOD.
  logic [RW-1:0] rep_cnt_q [N];
  logic [RW-1:0] rep_cnt_d [N];
  logic [N-1:0]  rep_arm_q, rep_arm_d;
  logic [RW-1:0] rep_nxt;
`endif

  logic [CW-1:0] cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      pulse_q <= '0;
      for (int i = 0; i < int'(N); i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
`ifdef BTN_REPEAT_EN
        rep_cnt_q[i] <= '0;
`endif
      end
`ifdef BTN_REPEAT_EN
      rep_arm_q <= '0;
`endif
    end else begin
      s1_q    <= btn_in;
      s2_q    <= s1_q;
      pulse_q <= pulse_d;
      for (int i = 0; i < int'(N); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef BTN_REPEAT_EN
        rep_cnt_q[i] <= rep_cnt_d[i];
`endif
      end
`ifdef BTN_REPEAT_EN
      rep_arm_q <= rep_arm_d;
`endif
    end
  end

  always_comb begin
    pulse_d = '0;
    cnt_nxt = '0;
`ifdef BTN_REPEAT_EN
    rep_arm_d = rep_arm_q;
    rep_nxt   = '0;
`endif
    for (int i = 0; i < int'(N); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cnt_nxt    = CW'(cnt_q[i] + 1'b1);
`ifdef BTN_REPEAT_EN
      rep_cnt_d[i] = rep_cnt_q[i];
      rep_nxt      = RW'(rep_cnt_q[i] + 1'b1);
`endif
      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (s2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s2_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_nxt == CW'(DB_CYCLES)) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            pulse_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_nxt;
          end
        end
        HELD: begin
          if (!s2_q[i]) begin
            state_d[i] = REL_WAIT;
            cnt_d[i]   = CW'(1);
          end
`ifdef BTN_REPEAT_EN
          else if ((!rep_arm_q[i] && rep_nxt == RW'(REP_DELAY)) ||
                   ( rep_arm_q[i] && rep_nxt == RW'(REP_PERIOD))) begin
            pulse_d[i]   = 1'b1;
            rep_cnt_d[i] = '0;
            rep_arm_d[i] = 1'b1;
          end else begin
            rep_cnt_d[i] = rep_nxt;
          end
`endif
        end
        REL_WAIT: begin
          if (s2_q[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_nxt == CW'(DB_CYCLES)) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
`ifdef BTN_REPEAT_EN
            rep_cnt_d[i] = '0;
            rep_arm_d[i] = 1'b0;
`endif
          end else begin
            cnt_d[i] = cnt_nxt;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    btn_level = '0;
    for (int i = 0; i < int'(N); i++) begin
      btn_level[i] = state_q[i][1];
    end
  end

  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_btn_cond.sv
// Directed bench for btn_cond: cycle-level reference model plus hand-computed literal checks.
module tb_btn_cond;
  localparam int unsigned N  = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 8;
  localparam int unsigned RP = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_pulse;

  int total = 0;
  int bad   = 0;

  btn_cond #(.N(N), .DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  always #5 clk = ~clk;

  // Reference: level flips once the synchronized input has disagreed with it for DB straight samples.
  logic [N-1:0] m_s1, m_s2, m_level, m_pulse;
  int           m_run  [N];
`ifdef BTN_REPEAT_EN
  int           m_hold [N];
`endif

  always @(posedge clk or posedge rst) begin
    logic s;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0;
      for (int i = 0; i < int'(N); i++) begin
        m_run[i] = 0;
`ifdef BTN_REPEAT_EN
        m_hold[i] = 0;
`endif
      end
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        s = m_s2[i];
        m_pulse[i] = 1'b0;
        if (s != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == int'(DB)) begin
            m_level[i] = s;
            m_pulse[i] = s;
            m_run[i]   = 0;
`ifdef BTN_REPEAT_EN
            m_hold[i]  = 0;
`endif
          end
        end else begin
`ifdef BTN_REPEAT_EN
          if (m_level[i] && m_run[i] == 0) begin
            m_hold[i] = m_hold[i] + 1;
            if (m_hold[i] >= int'(RD) && ((m_hold[i] - int'(RD)) % int'(RP)) == 0)
              m_pulse[i] = 1'b1;
          end
`endif
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      total = total + 1;
      if (btn_level !== m_level) begin
        bad = bad + 1;
        $display("FAIL model_level t=%0t: got %b want %b", $time, btn_level, m_level);
      end
      total = total + 1;
      if (btn_pulse !== m_pulse) begin
        bad = bad + 1;
        $display("FAIL model_pulse t=%0t: got %b want %b", $time, btn_pulse, m_pulse);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Watch one channel for a number of cycles: first pulse, pulse count, first level change (-1 = none).
  task automatic watch(input int ch, input int cycles, output int fp, output int np, output int fl);
    logic start;
    start = btn_level[ch];
    fp = -1; np = 0; fl = -1;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      if (btn_pulse[ch]) begin
        np = np + 1;
        if (fp < 0) fp = k;
      end
      if (fl < 0 && btn_level[ch] != start) fl = k;
    end
  endtask

  initial begin
    int fp, np, fl, bp;
    int idx [$];
    logic [N-1:0] bounce [5];

    // Reset with all buttons held: outputs quiet, then one all-channel pulse 6 edges after release
    btn_in = 4'b1111;
    #1;
    chk("rst_level", int'(btn_level), 0);
    chk("rst_pulse", int'(btn_pulse), 0);
    #2 rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("rst_pulse_k%0d", k), int'(btn_pulse), (k == 6) ? 15 : 0);
    end
    chk("rst_level_after", int'(btn_level), 15);
    btn_in = '0;
    repeat (12) @(negedge clk);
    chk("all_released", int'(btn_level), 0);

    // Clean press on channel 0
    btn_in[0] = 1'b1;
    watch(0, 20, fp, np, fl);
    chk("press_level_k", fl, 6);
    chk("press_pulse_k", fp, 6);
    chk("press_npulse", np, 1);
    chk("press_others", int'(btn_level[3:1]), 0);

    // Release on channel 0
    btn_in[0] = 1'b0;
    watch(0, 12, fp, np, fl);
    chk("release_level_k", fl, 6);
    chk("release_npulse", np, 0);

    // Bounce on channel 1 then hold
    bounce[0] = 4'b0010; bounce[1] = 4'b0000; bounce[2] = 4'b0010;
    bounce[3] = 4'b0010; bounce[4] = 4'b0000;
    bp = 0;
    for (int k = 0; k < 5; k++) begin
      btn_in = bounce[k];
      @(negedge clk);
      if (btn_pulse[1]) bp = bp + 1;
    end
    btn_in[1] = 1'b1;
    watch(1, 12, fp, np, fl);
    chk("bounce_pulses", bp, 0);
    chk("bounce_pulse_k", fp, 6);
    chk("bounce_npulse", np, 1);

    // Short glitch on channel 2
    np = 0; fl = 0;
    btn_in[2] = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (k == 3) btn_in[2] = 1'b0;
      if (btn_pulse[2]) np = np + 1;
      if (btn_level[2]) fl = 1;
    end
    chk("glitch_level", fl, 0);
    chk("glitch_npulse", np, 0);

    btn_in[1] = 1'b0;
    repeat (10) @(negedge clk);

    // Simultaneous presses on channels 0 and 2
    btn_in = 4'b0101;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("simul_pulse_k%0d", k), int'(btn_pulse), (k == 6) ? 5 : 0);
    end

    // Asynchronous reset mid-count, then held buttons re-qualify as new presses
    btn_in[3] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_level", int'(btn_level), 0);
    chk("midrst_pulse", int'(btn_pulse), 0);
    #3 rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_pulse_k%0d", k), int'(btn_pulse), (k == 6) ? 13 : 0);
    end

    btn_in = '0;
    repeat (12) @(negedge clk);

    // Long hold on channel 3: single pulse, or auto-repeat when enabled
    btn_in[3] = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (btn_pulse[3]) idx.push_back(k);
    end
    chk("hold_first_k", (idx.size() > 0) ? idx[0] : -1, 6);
`ifdef BTN_REPEAT_EN
    chk("rep_count", idx.size(), 9);
    chk("rep_second_k", (idx.size() > 1) ? idx[1] : -1, 14);
    chk("rep_third_k", (idx.size() > 2) ? idx[2] : -1, 17);
`else
    chk("hold_count", idx.size(), 1);
`endif
    btn_in[3] = 1'b0;
    np = 0; fl = -1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k >= 3 && btn_pulse[3]) np = np + 1;
      if (fl < 0 && !btn_level[3]) fl = k;
    end
    chk("hold_release_k", fl, 6);
    chk("hold_release_pulses", np, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
